// File: rtl/chacha_xor.sv
// chacha_xor: XORs a plaintext byte stream with keystream bytes pulled from the chacha core
//   clk, rst             : clock, synchronous active-high reset
//   blk_ready, ks_in     : core has a block available / keystream byte at core read address
//   rd_blk               : advance core read address (ks_in consumed this cycle)
//   pt_valid/ready/data  : plaintext input stream
//   ct_valid/ready/data  : registered ciphertext output stream
//   ks_pos, blk_done     : next keystream index within block / one-cycle end-of-block pulse
//   CHACHA_XOR_LAST_EN   : adds pt_last/ct_last; the rest of a block after a last byte is discarded
module chacha_xor #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              blk_ready,
   input  logic [7:0]        ks_in,
   output logic              rd_blk,
   input  logic              pt_valid,
   input  logic [7:0]        pt_data,
   output logic              pt_ready,
`ifdef CHACHA_XOR_LAST_EN
   input  logic              pt_last,
   output logic              ct_last,
`endif
   output logic              ct_valid,
   output logic [7:0]        ct_data,
   input  logic              ct_ready,
   output logic [ADDR_W-1:0] ks_pos,
   output logic              blk_done
);
   typedef enum logic [1:0] {IDLE, STREAM, DONE, SKIP} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ks_pos_q, ks_pos_d;
   logic              ct_valid_q, ct_valid_d;
   logic [7:0]        ct_data_q, ct_data_d;
   logic              fire, last_byte, last_in;
   assign last_byte = &ks_pos_q;
`ifdef CHACHA_XOR_LAST_EN
   logic ct_last_q, ct_last_d;
   assign last_in = pt_last;
   assign ct_last = ct_last_q;
`else
   assign last_in = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ks_pos_q   <= '0;
         ct_valid_q <= 1'b0;
         ct_data_q  <= '0;
`ifdef CHACHA_XOR_LAST_EN
         ct_last_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ks_pos_q   <= ks_pos_d;
         ct_valid_q <= ct_valid_d;
         ct_data_q  <= ct_data_d;
`ifdef CHACHA_XOR_LAST_EN
         ct_last_q  <= ct_last_d;
`endif
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (blk_ready) state_d = STREAM;
         STREAM:  if (fire) state_d = last_byte ? DONE : last_in ? SKIP : STREAM;
`ifdef CHACHA_XOR_LAST_EN
         SKIP:    if (last_byte) state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // A new byte may enter whenever the output register is empty or being drained.
   always_comb begin
      pt_ready = (state_q == STREAM) && (!ct_valid_q || ct_ready);
      fire     = pt_ready && pt_valid;
      rd_blk   = fire || (state_q == SKIP);
      blk_done = (state_q == DONE);
   end
   always_comb begin
      ks_pos_d   = rd_blk ? ks_pos_q + ADDR_W'(1) : ks_pos_q;
      ct_valid_d = fire || (ct_valid_q && !ct_ready);
      ct_data_d  = fire ? pt_data ^ ks_in : ct_data_q;
`ifdef CHACHA_XOR_LAST_EN
      ct_last_d  = fire ? pt_last : ct_last_q;
`endif
   end
   assign ct_valid = ct_valid_q;
   assign ct_data  = ct_data_q;
   assign ks_pos   = ks_pos_q;
endmodule
